// File: rtl/oled_arb_pkg.sv
// -----------------------------------------------------------------------------
// oled_arb_pkg
// Shared definitions for oled_write_arbiter:
//   - state_t      : FSM state encoding
//   - ROW/COL      : character address field positions inside the 9-bit address
//   - HOLD_W       : width of the auto-update holdoff counter
//   - sanitize_addr: forces the unused low address bits to zero
// -----------------------------------------------------------------------------
package oled_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ISSUE = 3'd1,
    S_WR_ACK   = 3'd2,
    S_WR_DONE  = 3'd3,
    S_UP_ISSUE = 3'd4,
    S_UP_ACK   = 3'd5,
    S_UP_DONE  = 3'd6
  } state_t;

  localparam int ADDR_W  = 9;
  localparam int ASCII_W = 8;
  localparam int ROW_MSB = 8;
  localparam int ROW_LSB = 7;
  localparam int COL_MSB = 6;
  localparam int COL_LSB = 3;
  localparam int HOLD_W  = 16;

  // Only row and column carry meaning; bits [2:0] are always sent as zero.
  localparam logic [ADDR_W-1:0] ADDR_KEEP_MASK = 9'h1F8;

  function automatic logic [ADDR_W-1:0] sanitize_addr(input logic [ADDR_W-1:0] a);
    return a & ADDR_KEEP_MASK;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts at i_last+1
// (modulo NREQ) and returns the first requesting index.
// Ports:
//   i_req   [NREQ-1:0] request vector
//   i_last  [1:0]      index of the previously granted requester
//   o_grant [NREQ-1:0] one-hot winner (all zero when nobody requests)
//   o_idx   [1:0]      encoded winner
//   o_valid            at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [1:0]      i_last,
  output logic [NREQ-1:0] o_grant,
  output logic [1:0]      o_idx,
  output logic            o_valid
);

  int w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_pos = (int'(i_last) + k) % NREQ;
      if (!o_valid && i_req[w_pos]) begin
        o_valid        = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = 2'(w_pos);
      end
    end
  end

endmodule

// File: rtl/oled_write_arbiter.sv
// -----------------------------------------------------------------------------
// oled_write_arbiter
// Shares the OLEDCtrl character-write and display-update command ports among
// NREQ (2..4) text producers. Writes are granted round-robin and issued with
// the start/ready handshake; display updates are issued on explicit request
// and, optionally, automatically after HOLDOFF idle cycles following writes.
//
// Build option: OLED_ARB_AUTOUPDATE_EN enables the automatic update holdoff
// counter. Without it, updates happen only on i_upd_req.
//
// Handshakes:
//   Requester side: i_req_valid[i] is held with stable addr/ascii until the
//   cycle in which o_req_ready[i] is high; that cycle transfers the write.
//   o_req_ready is one-hot and lasts a single cycle.
//   OLEDCtrl side: a command is only started while the matching ready is
//   high; o_*_start pulses one cycle, then the arbiter waits for ready to
//   drop (command taken) and rise again (command finished).
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_valid/o_req_ready per-requester write handshake
//   i_req_addr/i_req_ascii  packed per-requester address (9b) and char (8b)
//   i_upd_req/i_upd_clear   explicit update request pulse and clear select
//   o_upd_ack               pulse when an explicit update completes
//   o_wr_start/o_wr_addr/o_wr_ascii/i_wr_ready  OLEDCtrl write command
//   o_up_start/o_up_clear/i_up_ready            OLEDCtrl update command
//   o_grant_id              requester of the last accepted write
//   o_dirty                 pixel memory written since the last update
//   o_busy                  FSM not idle
//   o_state                 current FSM state (debug)
// -----------------------------------------------------------------------------
module oled_write_arbiter
  import oled_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int HOLDOFF = 1000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [9*NREQ-1:0]    i_req_addr,
  input  logic [8*NREQ-1:0]    i_req_ascii,
  input  logic                 i_upd_req,
  input  logic                 i_upd_clear,
  output logic                 o_upd_ack,
  output logic                 o_wr_start,
  output logic [ADDR_W-1:0]    o_wr_addr,
  output logic [ASCII_W-1:0]   o_wr_ascii,
  input  logic                 i_wr_ready,
  output logic                 o_up_start,
  output logic                 o_up_clear,
  input  logic                 i_up_ready,
  output logic [1:0]           o_grant_id,
  output logic                 o_dirty,
  output logic                 o_busy,
  output logic [2:0]           o_state
);

  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("oled_write_arbiter: NREQ must be 2..4");
  end
  if (HOLDOFF < 1 || HOLDOFF > 65535) begin : g_bad_holdoff
    $error("oled_write_arbiter: HOLDOFF must be 1..65535");
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_last;
  logic [1:0]           r_grant_id;
  logic [ADDR_W-1:0]    r_addr;
  logic [ASCII_W-1:0]   r_ascii;
  logic                 r_pend;     // sticky explicit update request
  logic                 r_clr;      // sticky clear selection for that request
  logic                 r_up_expl;  // update in flight was explicitly requested
  logic                 r_dirty;

  logic [NREQ-1:0]      w_grant;
  logic [1:0]           w_idx;
  logic                 w_any;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [ASCII_W-1:0]   w_sel_ascii;
  logic                 w_accept;
  logic                 w_go_up;
  logic                 w_wr_cpl;
  logic                 w_up_issue;
  logic                 w_up_cpl;
  logic                 w_auto;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .i_req   (i_req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  always_comb begin
    w_sel_addr  = '0;
    w_sel_ascii = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_idx == 2'(i)) begin
        w_sel_addr  = i_req_addr[9*i +: 9];
        w_sel_ascii = i_req_ascii[8*i +: 8];
      end
    end
  end

  // Decoded straight from the state so the holdoff counter does not form a
  // combinational loop through the next-state logic.
  assign w_wr_cpl   = (r_state == S_WR_DONE) && i_wr_ready;
  assign w_up_issue = (r_state == S_UP_ISSUE);
  assign w_up_cpl   = (r_state == S_UP_DONE) && i_up_ready;

`ifdef OLED_ARB_AUTOUPDATE_EN
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLDOFF);

  logic [HOLD_W-1:0] r_cnt;
  logic [HOLD_W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_wr_cpl || w_up_issue) begin
      w_cnt_nxt = '0;
    end else if ((r_state == S_IDLE) && r_dirty && !(|i_req_valid) &&
                 (r_cnt != HOLD_MAX)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Looking at the next count makes the update dispatch on the HOLDOFF-th
  // idle cycle, so up_start follows exactly HOLDOFF idle cycles.
  assign w_auto = r_dirty && (w_cnt_nxt == HOLD_MAX);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  assign w_auto = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_go_up     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A pending update outranks waiting writes.
        if ((r_pend || w_auto) && i_up_ready) begin
          w_go_up     = 1'b1;
          w_state_nxt = S_UP_ISSUE;
        end else if (w_any && i_wr_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WR_ISSUE;
        end
      end
      S_WR_ISSUE: w_state_nxt = S_WR_ACK;
      S_WR_ACK:   if (!i_wr_ready) w_state_nxt = S_WR_DONE;
      S_WR_DONE:  if (i_wr_ready)  w_state_nxt = S_IDLE;
      S_UP_ISSUE: w_state_nxt = S_UP_ACK;
      S_UP_ACK:   if (!i_up_ready) w_state_nxt = S_UP_DONE;
      S_UP_DONE:  if (i_up_ready)  w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_last     <= 2'(NREQ - 1);
      r_grant_id <= '0;
      r_addr     <= '0;
      r_ascii    <= '0;
      r_pend     <= 1'b0;
      r_clr      <= 1'b0;
      r_up_expl  <= 1'b0;
      r_dirty    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_last     <= w_idx;
        r_grant_id <= w_idx;
        r_addr     <= sanitize_addr(w_sel_addr);
        r_ascii    <= w_sel_ascii;
      end
      if (w_go_up) begin
        r_up_expl <= r_pend;
      end
      // The latch is consumed in UP_ISSUE; a request arriving in that same
      // cycle is kept for the following update.
      if (w_up_issue) begin
        r_pend <= i_upd_req;
        r_clr  <= i_upd_req & i_upd_clear;
      end else if (i_upd_req) begin
        r_pend <= 1'b1;
        r_clr  <= r_clr | i_upd_clear;
      end
      if (w_wr_cpl) begin
        r_dirty <= 1'b1;
      end else if (w_up_issue) begin
        r_dirty <= 1'b0;
      end
    end
  end

  assign o_req_ready = (w_accept && !i_rst) ? w_grant : '0;
  assign o_upd_ack   = w_up_cpl && r_up_expl && !i_rst;
  assign o_wr_start  = (r_state == S_WR_ISSUE);
  assign o_wr_addr   = r_addr;
  assign o_wr_ascii  = r_ascii;
  assign o_up_start  = w_up_issue;
  assign o_up_clear  = w_up_issue && r_clr;
  assign o_grant_id  = r_grant_id;
  assign o_dirty     = r_dirty;
  assign o_busy      = (r_state != S_IDLE);
  assign o_state     = r_state;

endmodule

// File: tb/tb_oled_write_arbiter.sv
module tb_oled_write_arbiter;

  localparam int NREQ    = 2;
  localparam int HOLDOFF = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [9*NREQ-1:0] req_addr;
  logic [8*NREQ-1:0] req_ascii;
  logic              upd_req, upd_clear, upd_ack;
  logic              wr_start, wr_ready;
  logic [8:0]        wr_addr;
  logic [7:0]        wr_ascii;
  logic              up_start, up_clear, up_ready;
  logic [1:0]        grant_id;
  logic              dirty, busy;
  logic [2:0]        state;

  oled_write_arbiter #(.NREQ(NREQ), .HOLDOFF(HOLDOFF)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .i_req_ascii (req_ascii),
    .i_upd_req   (upd_req),
    .i_upd_clear (upd_clear),
    .o_upd_ack   (upd_ack),
    .o_wr_start  (wr_start),
    .o_wr_addr   (wr_addr),
    .o_wr_ascii  (wr_ascii),
    .i_wr_ready  (wr_ready),
    .o_up_start  (up_start),
    .o_up_clear  (up_clear),
    .i_up_ready  (up_ready),
    .o_grant_id  (grant_id),
    .o_dirty     (dirty),
    .o_busy      (busy),
    .o_state     (state)
  );

  // scoreboard: {grant_id, wr_addr, wr_ascii}
  logic [18:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // requester model
  logic [8:0] d_addr[NREQ];
  logic [7:0] d_ascii[NREQ];
  int         rem[NREQ];
  int         mdl_last;

  function automatic logic [8:0] clean_addr(input logic [8:0] a);
    clean_addr = {a[8:3], 3'b000};
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = (rem[i] > 0);
      req_addr[9*i +: 9]   = d_addr[i];
      req_ascii[8*i +: 8]  = d_ascii[i];
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    upd_req   = 1'b0;
    upd_clear = 1'b0;
    wr_ready  = 1'b1;
    up_ready  = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      rem[i]     = 0;
      d_addr[i]  = 9'($urandom_range(0, 511));
      d_ascii[i] = 8'($urandom_range(32, 126));
    end
    drive_reqs();
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    mdl_last = NREQ - 1;
    exp_q.delete();
  endtask

  // Called at posedge+1 of a cycle in which the DUT is idle with requests
  // driven; expects acceptance in that cycle and serves the write with an
  // OLEDCtrl ready drop of d cycles. Returns at posedge+1 of the next idle
  // cycle with requests re-driven.
  task automatic do_write(input int d);
    logic [NREQ-1:0] exp_rdy;
    logic [18:0]     exp_w;
    int              win;
    win = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (mdl_last + k) % NREQ;
      if (win < 0 && rem[i] > 0) win = i;
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    exp_w = '0;
    @(negedge clk);
    n_vec++;
    if (req_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_rdy);
    end
    if (win >= 0) begin
      exp_q.push_back({2'(win), clean_addr(d_addr[win]), d_ascii[win]});
      mdl_last     = win;
      rem[win]     = rem[win] - 1;
      d_addr[win]  = 9'($urandom_range(0, 511));
      d_ascii[win] = 8'($urandom_range(32, 126));
    end
    @(posedge clk); #1;
    drive_reqs();
    @(negedge clk);
    n_vec++;
    if (wr_start !== 1'b1) begin
      n_err++;
      $display("FAIL wr_start: got %b expected 1", wr_start);
    end
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL write_data: scoreboard empty, got %h", {grant_id, wr_addr, wr_ascii});
    end else begin
      exp_w = exp_q.pop_front();
      if ({grant_id, wr_addr, wr_ascii} !== exp_w) begin
        n_err++;
        $display("FAIL write_data: got id=%0d addr=%h ascii=%h expected id=%0d addr=%h ascii=%h",
                 grant_id, wr_addr, wr_ascii, exp_w[18:17], exp_w[16:8], exp_w[7:0]);
      end
    end
    @(posedge clk); #1;
    wr_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (wr_start !== 1'b0 || {wr_addr, wr_ascii} !== exp_w[16:0]) begin
      n_err++;
      $display("FAIL wr_hold: wr_start=%b addr=%h ascii=%h expected 0 %h %h",
               wr_start, wr_addr, wr_ascii, exp_w[16:8], exp_w[7:0]);
    end
    repeat (d) begin
      @(posedge clk); #1;
    end
    wr_ready = 1'b1;
    @(posedge clk); #1;
    drive_reqs();
    n_vec++;
    if (dirty !== 1'b1) begin
      n_err++;
      $display("FAIL dirty_set: got %b expected 1", dirty);
    end
  endtask

  // Called at the negedge of the cycle expected to carry up_start.
  task automatic serve_update(input int d, input logic exp_clr, input logic exp_ack,
                              input logic relatch);
    n_vec++;
    if ({up_start, up_clear} !== {1'b1, exp_clr}) begin
      n_err++;
      $display("FAIL up_issue: up_start=%b up_clear=%b expected 1 %b", up_start, up_clear, exp_clr);
    end
    @(posedge clk); #1;
    up_ready = 1'b0;
    if (relatch) begin
      upd_req   = 1'b1;
      upd_clear = 1'b0;
    end
    @(negedge clk);
    n_vec++;
    if ({up_start, up_clear, upd_ack, dirty} !== 4'b0000) begin
      n_err++;
      $display("FAIL up_ack_wait: start=%b clear=%b ack=%b dirty=%b expected all 0",
               up_start, up_clear, upd_ack, dirty);
    end
    @(posedge clk); #1;
    upd_req = 1'b0;
    repeat (d - 1) begin
      @(posedge clk); #1;
    end
    up_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (upd_ack !== exp_ack) begin
      n_err++;
      $display("FAIL upd_ack: got %b expected %b", upd_ack, exp_ack);
    end
    @(posedge clk); #1;
    drive_reqs();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_vec++;
    if ({req_ready, upd_ack, wr_start, wr_addr, wr_ascii, up_start, up_clear,
         grant_id, dirty, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy=%b ack=%b ws=%b wa=%h wc=%h us=%b uc=%b id=%0d dirty=%b busy=%b expected all 0",
               req_ready, upd_ack, wr_start, wr_addr, wr_ascii, up_start, up_clear,
               grant_id, dirty, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    d_addr[0]  = 9'h108;
    d_ascii[0] = 8'h41;
    rem[0]     = 1;
    drive_reqs();
    do_write(1);
  endtask

  task automatic test_round_robin();
    do_reset();
    rem[0] = 2;
    rem[1] = 2;
    drive_reqs();
    repeat (4) do_write($urandom_range(1, 3));
  endtask

  task automatic test_back_to_back();
    rem[1] = 3;
    drive_reqs();
    for (int k = 1; k <= 3; k++) do_write(k);
  endtask

  task automatic test_clear_update();
    do_reset();
    rem[0] = 1;
    drive_reqs();
    do_write(1);
    rem[0]    = 1;
    rem[1]    = 1;
    wr_ready  = 1'b0;
    upd_req   = 1'b1;
    upd_clear = 1'b1;
    drive_reqs();
    @(negedge clk);
    n_vec++;
    if (req_ready !== '0) begin
      n_err++;
      $display("FAIL no_grant_wr_busy: req_ready=%b expected 00", req_ready);
    end
    @(posedge clk); #1;
    upd_req   = 1'b0;
    upd_clear = 1'b0;
    wr_ready  = 1'b1;
    @(negedge clk);
    n_vec++;
    if (req_ready !== '0) begin
      n_err++;
      $display("FAIL update_wins: req_ready=%b expected 00", req_ready);
    end
    @(negedge clk);
    serve_update(1, 1'b1, 1'b1, 1'b1);
    // request latched during the first update runs next, without clear
    @(negedge clk);
    n_vec++;
    if (req_ready !== '0) begin
      n_err++;
      $display("FAIL relatched_wins: req_ready=%b expected 00", req_ready);
    end
    @(negedge clk);
    serve_update(2, 1'b0, 1'b1, 1'b0);
    do_write(1);
    do_write(2);
  endtask

  task automatic test_auto_update();
    int k;
    bit found;
    do_reset();
    rem[0] = 1;
    drive_reqs();
    do_write(1);
    k     = 0;
    found = 0;
    while (!found && k < 3 * HOLDOFF) begin
      @(negedge clk);
      if (up_start === 1'b1) found = 1;
      else k++;
    end
`ifdef OLED_ARB_AUTOUPDATE_EN
    n_vec++;
    if (!found || k != HOLDOFF) begin
      n_err++;
      $display("FAIL auto_holdoff: found=%0d idle_cycles=%0d expected %0d", found, k, HOLDOFF);
    end
    if (found) serve_update(1, 1'b0, 1'b0, 1'b0);
`else
    n_vec++;
    if (found) begin
      n_err++;
      $display("FAIL no_auto_update: up_start after %0d cycles expected none", k);
    end
    n_vec++;
    if (dirty !== 1'b1) begin
      n_err++;
      $display("FAIL dirty_kept: got %b expected 1", dirty);
    end
`endif
  endtask

  task automatic test_reset_midop();
    do_reset();
    rem[0] = 1;
    drive_reqs();
    @(negedge clk);
    n_vec++;
    if (req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL midop_grant: req_ready=%b expected 01", req_ready);
    end
    rem[0] = 0;
    @(posedge clk); #1;
    drive_reqs();
    @(negedge clk);
    n_vec++;
    if (wr_start !== 1'b1) begin
      n_err++;
      $display("FAIL midop_start: wr_start=%b expected 1", wr_start);
    end
    @(posedge clk); #1;
    wr_ready = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    mdl_last = NREQ - 1;
    rem[1]   = 1;
    drive_reqs();
    @(negedge clk);
    n_vec++;
    if ({req_ready, upd_ack, wr_start, wr_addr, wr_ascii, up_start, up_clear,
         grant_id, dirty, busy} !== '0) begin
      n_err++;
      $display("FAIL midop_reset_outputs: rdy=%b ws=%b wa=%h wc=%h id=%0d dirty=%b busy=%b expected all 0",
               req_ready, wr_start, wr_addr, wr_ascii, grant_id, dirty, busy);
    end
    repeat (4) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_vec++;
      if (req_ready !== '0 || wr_start !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL midop_hold: rdy=%b ws=%b busy=%b expected 00 0 0", req_ready, wr_start, busy);
      end
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
    do_write(1);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_ascii = '0;
    upd_req   = 1'b0;
    upd_clear = 1'b0;
    wr_ready  = 1'b1;
    up_ready  = 1'b1;

    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_clear_update();
    test_auto_update();
    test_reset_midop();

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/oled_write_arbiter.md
# oled_write_arbiter

Shares the OLEDCtrl character-write and display-update command ports between up to four text producers (CPU PC/instruction formatter, boot banner, debug status). It accepts per-requester (address, ASCII) writes over valid/ready, grants them round-robin, and issues each one to OLEDCtrl with the start/ready handshake. It also schedules display updates so the local pixel memory is flushed to the panel after writes.

## Interface
- `NREQ`, default 2: number of requesters, legal range 2..4.
- `HOLDOFF`, default 1000: idle cycles after the last write before an automatic update is issued. Legal range 1..65535.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in NREQ: write request, one bit per requester.
- `req_ready` out NREQ: write accepted, one-hot, asserted for one cycle.
- `req_addr` in 9*NREQ: requester i uses bits [9i+8:9i]. Bits [8:7] are the row, bits [6:3] are the column, bits [2:0] must be 0.
- `req_ascii` in 8*NREQ: requester i uses bits [8i+7:8i].
- `upd_req` in 1: explicit update request, one-cycle pulse.
- `upd_clear` in 1: sampled together with `upd_req`; selects a clear-display update.
- `upd_ack` out 1: one-cycle pulse when a requested update completes.
- `wr_start` out 1: write command to OLEDCtrl.
- `wr_addr` out 9: write address to OLEDCtrl.
- `wr_ascii` out 8: write character to OLEDCtrl.
- `wr_ready` in 1: OLEDCtrl write ready.
- `up_start` out 1: update command to OLEDCtrl.
- `up_clear` out 1: update-clear flag to OLEDCtrl.
- `up_ready` in 1: OLEDCtrl update ready.
- `grant_id` out 2: requester of the last accepted write.
- `dirty` out 1: pixel memory has been written since the last update.
- `busy` out 1: FSM is not in IDLE.

## Operation
- **States:** IDLE, WR_ISSUE, WR_ACK, WR_DONE, UP_ISSUE, UP_ACK, UP_DONE.
- **IDLE, dispatch priority:**
  1. A pending update (latched explicit request, or automatic) when `up_ready` is high goes to UP_ISSUE.
  2. Otherwise, any `req_valid` bit set while `wr_ready` is high selects the round-robin winner. The search starts at `last+1` modulo NREQ.
  3. The winner gets `req_ready[i]` for that cycle. Its addr/ascii are captured, `grant_id` is set to i, `last` is set to i, and the FSM goes to WR_ISSUE.
- **WR_ISSUE:** `wr_start`=1 for exactly one cycle, then go to WR_ACK.
- **WR_ACK:** wait for `wr_ready`=0, then go to WR_DONE.
- **WR_DONE:** wait for `wr_ready`=1. Then set `dirty`, zero the holdoff counter, and return to IDLE.
- **Update path:** the same three-step sequence with `up_start` and `up_ready`.
  - `up_clear` is driven from the latched clear bit during UP_ISSUE and is 0 otherwise.
  - `dirty` clears at UP_ISSUE.
  - `upd_ack` pulses on UP_DONE exit only if the update was explicit.
- **Explicit-request latch:** `upd_req` sets a sticky pending bit and `upd_clear` is ORed into the latched clear bit. Both are cleared at UP_ISSUE. A `upd_req` arriving during an update is latched for the next update.
- **Round-robin pointer:** `last` resets to NREQ-1, so requester 0 has first priority. Invalid `req_addr` low bits are forced to 0.
- **Reset mid-operation:** the FSM returns to IDLE and the latches clear. The OLEDCtrl operation already in flight is not aborted. No new command is issued until the corresponding ready is high.

## Timing
- **Reset values:** all outputs 0, `grant_id`=0, `last`=NREQ-1, pending/clear/dirty=0, holdoff counter=0.
- **Acceptance to command:** acceptance at cycle T (`req_ready` high), `wr_start` at T+1. `wr_addr` and `wr_ascii` are held stable from T+1 until the return to IDLE.
- **Back-to-back writes:** a new grant is possible one cycle after WR_DONE sees `wr_ready`. With an OLEDCtrl ready drop of d cycles, the minimum spacing is 3+d cycles.
- **Simultaneous `req_valid` and pending update in IDLE:** the update wins and no `req_ready` is asserted that cycle.
- **Fairness:** a requester holding `req_valid` is granted within NREQ writes plus at most one update.

## Configuration
- **`OLED_ARB_AUTOUPDATE_EN` defined:**
  - The 16-bit holdoff counter increments in IDLE while `dirty`=1 and `req_valid`=0, saturating at HOLDOFF.
  - Reaching HOLDOFF raises an automatic update with clear=0.
  - Any write completion resets the counter to 0.
- **`OLED_ARB_AUTOUPDATE_EN` undefined:** the counter is not instantiated and updates occur only on `upd_req`. `dirty` is still maintained.

## Structure
- **Package `oled_arb_pkg`:** FSM state encoding, address field constants (ROW [8:7], COL [6:3]), and a 16-bit holdoff width constant.
- **Sub-module `rr_arbiter`:** NREQ-wide request vector plus `last` pointer in, one-hot grant and encoded index out. Purely combinational; the pointer register stays in `oled_write_arbiter`.

## Test plan
- **Single write:** reset, then `req_valid`=01, addr 0x108, ascii 0x41 → `req_ready`=01, `wr_start` one cycle later with `wr_addr`=0x108 and `wr_ascii`=0x41, `dirty`=1 after the `wr_ready` low→high.
- **Round-robin:** both requesters hold `req_valid` for 4 writes → grants alternate 0,1,0,1 and `grant_id` follows.
- **Explicit clear update:** `upd_req` with `upd_clear`=1 while requests are pending → `up_start` with `up_clear`=1 is issued before the next write, `upd_ack` pulses once, `dirty`=0.
- **Automatic update:** macro defined, HOLDOFF=10, one write then idle → `up_start` 10 cycles after write completion with `up_clear`=0 and no `upd_ack`. Macro undefined: no `up_start`.
- **Reset mid-operation:** `rst` asserted in WR_ACK with `wr_ready` still low → all outputs 0 next cycle, and no `wr_start` until `wr_ready`=1 with a fresh request.
